// File: rtl/nios_crc_pkg.sv
// Shared CRC-32 constants, reader state encoding and the byte-step helper.
package nios_crc_pkg;

  localparam int unsigned CRC_W = 32;

  localparam logic [CRC_W-1:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [CRC_W-1:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC_XOROUT    = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // One reflected CRC-32 byte step, LSB-first.
  function automatic logic [CRC_W-1:0] crc32_byte(input logic [CRC_W-1:0] crc,
                                                  input logic [7:0]       data);
    logic [CRC_W-1:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_word_update.sv
// Combinational CRC-32 update over one 32-bit word, bytes fed little-endian.
module crc32_word_update
  import nios_crc_pkg::*;
(
  input  logic [CRC_W-1:0] i_crc,
  input  logic [31:0]      i_word,
  output logic [CRC_W-1:0] o_crc_c
);

  logic [CRC_W-1:0] w_b0;
  logic [CRC_W-1:0] w_b1;
  logic [CRC_W-1:0] w_b2;

  // Four chained byte steps, readdata[7:0] first.
  assign w_b0    = crc32_byte(i_crc, i_word[7:0]);
  assign w_b1    = crc32_byte(w_b0,  i_word[15:8]);
  assign w_b2    = crc32_byte(w_b1,  i_word[23:16]);
  assign o_crc_c = crc32_byte(w_b2,  i_word[31:24]);

endmodule

// File: rtl/nios_project_crc_mem_reader.sv
// Avalon-MM read master: reads word_count words from base_addr, one at a time,
// and produces the CRC-32 of the stream. Define CRC_READER_CMP_EN to add the
// expected_crc input and crc_match output.
module nios_project_crc_mem_reader
  import nios_crc_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LEN_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
`ifdef CRC_READER_CMP_EN
  input  logic [31:0]       expected_crc,
  output logic              crc_match,
`endif
  output logic              busy,
  output logic              done,
  output logic [31:0]       crc_out,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_avm_read;
  logic              r_busy;
  logic              r_done;
  logic              w_avm_read_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [CRC_W-1:0]  r_crc;
  logic [CRC_W-1:0]  r_crc_out;
  logic [CRC_W-1:0]  w_crc_fold;
  logic [CRC_W-1:0]  w_crc_final;
  logic              w_start_ok;
  logic              w_fold;
  logic              w_last;

  assign w_start_ok = start && (r_state == IDLE);
  assign w_fold     = (r_state == WAIT) && avm_readdatavalid;
  assign w_last     = (r_remaining == LEN_W'(1));
  // DONE is entered either straight from IDLE (zero words) or from a WAIT fold.
  assign w_crc_final = (r_state == WAIT) ? w_crc_fold : CRC_INIT;

  assign busy           = r_busy;
  assign done           = r_done;
  assign crc_out        = r_crc_out;
  assign avm_address    = r_addr;
  assign avm_read       = r_avm_read;
  assign avm_byteenable = 4'b1111;

  crc32_word_update u_crc_word (
    .i_crc   (r_crc),
    .i_word  (avm_readdata),
    .o_crc_c (w_crc_fold)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; one read outstanding at a time.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (word_count == LEN_W'(0)) ? DONE : REQ;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (avm_readdatavalid) begin
          w_state_nxt = w_last ? DONE : REQ;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode of the upcoming state so the registered outputs align with it.
  always_comb begin
    w_avm_read_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    case (w_state_nxt)
      IDLE: ;
      REQ: begin
        w_avm_read_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      WAIT: w_busy_nxt = 1'b1;
      DONE: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_avm_read <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_avm_read <= w_avm_read_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Address, remaining count and running CRC; result captured on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_crc       <= CRC_INIT;
      r_crc_out   <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr      <= base_addr;
        r_remaining <= word_count;
        r_crc       <= CRC_INIT;
      end else if (w_fold) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
        r_crc       <= w_crc_fold;
      end
      if (w_state_nxt == DONE) begin
        r_crc_out <= w_crc_final ^ CRC_XOROUT;
      end
    end
  end

`ifdef CRC_READER_CMP_EN
  logic [31:0] r_expected;
  logic        r_crc_match;
  logic [31:0] w_expected;

  // A zero-length job enters DONE on the start edge, before r_expected loads.
  assign w_expected = (r_state == IDLE) ? expected_crc : r_expected;
  assign crc_match  = r_crc_match;

  // Expected value capture and result comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_expected  <= '0;
      r_crc_match <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_expected <= expected_crc;
      end
      if (w_state_nxt == DONE) begin
        r_crc_match <= ((w_crc_final ^ CRC_XOROUT) == w_expected);
      end
    end
  end
`endif

endmodule

// File: tb/tb_nios_project_crc_mem_reader.sv
// Directed bench for nios_project_crc_mem_reader with a negedge-driven
// Avalon-MM memory slave (1-cycle read latency, optional stalls and stray
// readdatavalid pulses). Define CRC_READER_CMP_EN to exercise crc_match.
module tb_nios_project_crc_mem_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] crc_out;
  logic [12:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest   = 1'b0;
  logic [31:0] avm_readdata      = 32'h0;
  logic        avm_readdatavalid = 1'b0;
`ifdef CRC_READER_CMP_EN
  logic [31:0] expected_crc;
  logic        crc_match;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Slave model state
  logic [31:0] mem [0:8191];
  logic [12:0] addr_log [0:15];
  logic        stall_en = 1'b0;
  logic        stray_en = 1'b0;
  logic        resp_pending = 1'b0;
  logic [12:0] resp_addr = 13'h0;
  logic        in_req = 1'b0;
  logic [12:0] held_addr = 13'h0;
  int          stall_left = 0;
  int          accepted = 0;
  int          reads_seen = 0;
  int          addr_violations = 0;

  always #5 clk = ~clk;

  nios_project_crc_mem_reader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
`ifdef CRC_READER_CMP_EN
    .expected_crc      (expected_crc),
    .crc_match         (crc_match),
`endif
    .busy              (busy),
    .done              (done),
    .crc_out           (crc_out),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  // Memory slave: responds one cycle after acceptance, stalls 0-3 cycles when enabled.
  always @(negedge clk) begin
    if (resp_pending) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem[resp_addr];
      resp_pending      = 1'b0;
    end else if (stray_en && avm_read && ($urandom_range(0, 1) == 0)) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = $urandom;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'hDEADBEEF;
    end
    if (avm_read) begin
      reads_seen++;
      if (!in_req) begin
        in_req     = 1'b1;
        held_addr  = avm_address;
        stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
      end else if (avm_address !== held_addr) begin
        addr_violations++;
      end
      if (stall_left != 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest         = 1'b0;
        resp_pending            = 1'b1;
        resp_addr               = avm_address;
        addr_log[accepted % 16] = avm_address;
        accepted++;
        in_req                  = 1'b0;
      end
    end else begin
      avm_waitrequest = 1'b0;
      in_req          = 1'b0;
    end
  end

  // Reference CRC-32: bit-serial over the word, LSB first.
  function automatic logic [31:0] model_word(input logic [31:0] crc, input logic [31:0] w);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 32; i++) begin
      fb = c[0] ^ w[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  function automatic logic [31:0] model_block(input int b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = model_word(c, mem[(b + i) % 8192]);
    return c ^ 32'hFFFFFFFF;
  endfunction

  // Start a job and wait (bounded) for done; cycles counted from the start edge.
  task automatic run(input logic [12:0] b, input logic [13:0] n,
                     output int cyc, output logic [31:0] crc, output logic ok);
    @(posedge clk); #1;
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok  = (done === 1'b1);
    crc = crc_out;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (avm_read !== 1'b0) $display("FAIL rst_avm_read: got %b expected 0", avm_read); else n_pass++;
    n_checks++; if (avm_address !== 13'h0) $display("FAIL rst_avm_address: got %h expected 0000", avm_address); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (crc_out !== 32'h0) $display("FAIL rst_crc_out: got %h expected 00000000", crc_out); else n_pass++;
    n_checks++; if (avm_byteenable !== 4'hF) $display("FAIL rst_byteenable: got %h expected f", avm_byteenable); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_single_word;
    int cyc; logic [31:0] crc; logic ok;
    mem[0] = 32'h34333231;
    run(13'h0000, 14'd1, cyc, crc, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: got no done expected done"); else n_pass++;
    n_checks++; if (cyc !== 3) $display("FAIL single_latency: got %0d expected 3", cyc); else n_pass++;
    n_checks++; if (crc !== 32'h9BE3E0A3) $display("FAIL single_crc: got %h expected 9be3e0a3", crc); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_at_done: got %b expected 1", busy); else n_pass++;
    // start coinciding with done must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL start_at_done_busy: got %b expected 0", busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (avm_read !== 1'b0) $display("FAIL start_at_done_read: got %b expected 0", avm_read); else n_pass++;
    n_checks++; if (crc_out !== 32'h9BE3E0A3) $display("FAIL crc_out_hold: got %h expected 9be3e0a3", crc_out); else n_pass++;
  endtask

  task automatic test_zero_cases;
    int cyc; logic [31:0] crc; logic ok; int r0;
    mem[0] = 32'h00000000;
    run(13'h0000, 14'd1, cyc, crc, ok);
    n_checks++; if (crc !== 32'h2144DF1C) $display("FAIL zero_word_crc: got %h expected 2144df1c", crc); else n_pass++;
    r0 = reads_seen;
    run(13'h0123, 14'd0, cyc, crc, ok);
    n_checks++; if (cyc !== 1) $display("FAIL count0_latency: got %0d expected 1", cyc); else n_pass++;
    n_checks++; if (crc !== 32'h0) $display("FAIL count0_crc: got %h expected 00000000", crc); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (reads_seen - r0 !== 0) $display("FAIL count0_reads: got %0d expected 0", reads_seen - r0); else n_pass++;
  endtask

  task automatic test_wrap;
    int cyc; logic [31:0] crc, exp; logic ok; int a0;
    mem[13'h1FFF] = 32'hCAFEF00D;
    mem[0]        = 32'h01234567;
    exp = model_block(32'h1FFF, 2);
    a0  = accepted;
    run(13'h1FFF, 14'd2, cyc, crc, ok);
    n_checks++; if (addr_log[a0 % 16] !== 13'h1FFF) $display("FAIL wrap_addr0: got %h expected 1fff", addr_log[a0 % 16]); else n_pass++;
    n_checks++; if (addr_log[(a0 + 1) % 16] !== 13'h0000) $display("FAIL wrap_addr1: got %h expected 0000", addr_log[(a0 + 1) % 16]); else n_pass++;
    n_checks++; if (crc !== exp) $display("FAIL wrap_crc: got %h expected %h", crc, exp); else n_pass++;
    n_checks++; if (cyc !== 5) $display("FAIL wrap_latency: got %0d expected 5", cyc); else n_pass++;
  endtask

  task automatic test_start_ignored;
    int cyc, a0; logic [31:0] exp;
    exp = model_block(32'h200, 3);
    @(posedge clk); #1;
    a0 = accepted;
    base_addr = 13'h200; word_count = 14'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    @(posedge clk); #1;
    cyc++;
    base_addr = 13'h0; word_count = 14'd0; start = 1'b1;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (cyc !== 7) $display("FAIL busy_start_latency: got %0d expected 7", cyc); else n_pass++;
    n_checks++; if (crc_out !== exp) $display("FAIL busy_start_crc: got %h expected %h", crc_out, exp); else n_pass++;
    n_checks++; if (accepted - a0 !== 3) $display("FAIL busy_start_reads: got %0d expected 3", accepted - a0); else n_pass++;
  endtask

  task automatic test_stall;
    int cyc, a0, v0; logic [31:0] crc, exp; logic ok;
    exp = model_block(32'h100, 6);
    run(13'h0100, 14'd6, cyc, crc, ok);
    n_checks++; if (crc !== exp) $display("FAIL nowait_crc: got %h expected %h", crc, exp); else n_pass++;
    n_checks++; if (cyc !== 13) $display("FAIL nowait_latency: got %0d expected 13", cyc); else n_pass++;
    stall_en = 1'b1;
    stray_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a0 = accepted;
      v0 = addr_violations;
      run(13'h0100, 14'd6, cyc, crc, ok);
      n_checks++; if (!ok) $display("FAIL stall_timeout: got no done expected done"); else n_pass++;
      n_checks++; if (crc !== exp) $display("FAIL stall_crc: got %h expected %h", crc, exp); else n_pass++;
      n_checks++; if (accepted - a0 !== 6) $display("FAIL stall_reads: got %0d expected 6", accepted - a0); else n_pass++;
      n_checks++; if (addr_violations - v0 !== 0) $display("FAIL stall_addr_stable: got %0d changes expected 0", addr_violations - v0); else n_pass++;
    end
    stall_en = 1'b0;
    stray_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc, a0, guard; logic [31:0] crc, exp; logic ok;
    exp = model_block(32'h300, 10);
    @(posedge clk); #1;
    a0 = accepted;
    base_addr = 13'h300; word_count = 14'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while ((accepted - a0) < 5 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++; if (accepted - a0 !== 5) $display("FAIL midrst_reach_word5: got %0d expected 5", accepted - a0); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (avm_read !== 1'b0) $display("FAIL midrst_read: got %b expected 0", avm_read); else n_pass++;
    n_checks++; if (avm_address !== 13'h0) $display("FAIL midrst_addr: got %h expected 0000", avm_address); else n_pass++;
    #1;
    reset = 1'b0;
    // the late response arrives on the next edge and must be ignored
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL late_rdv_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL late_rdv_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (crc_out !== 32'h0) $display("FAIL late_rdv_crc_out: got %h expected 00000000", crc_out); else n_pass++;
    run(13'h0300, 14'd10, cyc, crc, ok);
    n_checks++; if (crc !== exp) $display("FAIL midrst_rerun_crc: got %h expected %h", crc, exp); else n_pass++;
    n_checks++; if (cyc !== 21) $display("FAIL midrst_rerun_latency: got %0d expected 21", cyc); else n_pass++;
  endtask

`ifdef CRC_READER_CMP_EN
  task automatic test_compare;
    int cyc; logic [31:0] crc; logic ok;
    mem[0] = 32'h34333231;
    expected_crc = 32'h9BE3E0A3;
    run(13'h0000, 14'd1, cyc, crc, ok);
    n_checks++; if (crc_match !== 1'b1) $display("FAIL cmp_match: got %b expected 1", crc_match); else n_pass++;
    expected_crc = 32'h00000000;
    run(13'h0000, 14'd1, cyc, crc, ok);
    n_checks++; if (crc_match !== 1'b0) $display("FAIL cmp_mismatch: got %b expected 0", crc_match); else n_pass++;
    // zero-length job: final CRC is 0, so expected 0 matches
    run(13'h0000, 14'd0, cyc, crc, ok);
    n_checks++; if (crc_match !== 1'b1) $display("FAIL cmp_count0: got %b expected 1", crc_match); else n_pass++;
  endtask
`endif

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = 13'h0;
    word_count = 14'd0;
`ifdef CRC_READER_CMP_EN
    expected_crc = 32'h0;
`endif
    for (int i = 0; i < 8192; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    for (int i = 0; i < 16; i++) addr_log[i] = 13'h0;

    test_reset;
    test_single_word;
    test_zero_cases;
    test_wrap;
    test_start_ignored;
    test_stall;
    test_reset_mid;
`ifdef CRC_READER_CMP_EN
    test_compare;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nios_project_crc_mem_reader.md
# nios_project_crc_mem_reader

Avalon-MM read master that streams a block of 32-bit words out of the on-chip memory slave (s1/s2 port, 13-bit word address) and computes a standard CRC-32 over them. Sits beside the Nios II CPU on the system interconnect. Software writes a base address and a word count, pulses start, then collects the CRC once done.

## Interface
- ADDR_W, 13: word-address width; matches the 8192-word memory.
- LEN_W, 14: width of the word count; counts 0..8192 inclusive.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; all state is cleared immediately.
- start  in  1  single-cycle request; accepted only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled on start.
- word_count  in  LEN_W  number of words; sampled on start.
- busy  out  1  high from the cycle after start through the cycle done pulses.
- done  out  1  one-cycle pulse when crc_out is valid.
- crc_out  out  32  final CRC; holds its value until the next accepted start.
- avm_address  out  ADDR_W  word address of the current read.
- avm_read  out  1  read request.
- avm_byteenable  out  4  constant 4'b1111.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.

## Operation
- CRC-32 definition: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, final XOR 0xFFFFFFFF.
- Bytes are fed little-endian: readdata[7:0] first, readdata[31:24] last.
- State machine:
  - IDLE -> REQ on start with word_count≠0.
  - IDLE -> DONE on start with word_count=0.
  - REQ: avm_read=1 with a stable address; stays in REQ while avm_waitrequest=1; moves to WAIT when avm_waitrequest=0.
  - WAIT: on avm_readdatavalid, folds the word into the CRC, increments the address and decrements the remaining count. Goes to DONE if the remaining count reaches 0, otherwise back to REQ.
  - DONE: pulses done, latches crc_out = crc ^ 0xFFFFFFFF, then returns to IDLE.
- At most one read is outstanding at any time.
- avm_readdatavalid is ignored outside WAIT.
- Address arithmetic is modulo 2^ADDR_W: 0x1FFF is followed by 0x0000.
- start is ignored while busy. start in the same cycle as done is also ignored, because the block is not yet in IDLE.
- Reset mid-transfer: the block drops to IDLE immediately with avm_read=0, and the outstanding read response is discarded.
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, crc_out=0, internal crc=0xFFFFFFFF.

## Timing
- avm_read is registered and deasserts in the cycle after the slave accepts the request.
- With no waitrequest and the slave's 1-cycle read latency, each word takes 2 cycles.
- The start-to-done pulse takes 2N+1 cycles.
- The CRC update is combinational within the readdatavalid cycle and is registered at the edge.
- crc_out changes only on the DONE cycle edge, so it is valid in the same cycle as done=1.

## Configuration
- CRC_READER_CMP_EN, when defined, adds:
  - Input expected_crc[31:0], sampled on start.
  - Output crc_match, registered at DONE as (final crc == expected_crc). It is 0 on reset and held until the next start.
- Without the macro, neither port exists and no compare logic is built.

## Structure
- Package nios_crc_pkg holds:
  - CRC_POLY_REFL = 32'hEDB88320, CRC_INIT = 32'hFFFFFFFF, CRC_XOROUT = 32'hFFFFFFFF.
  - The state enum (IDLE, REQ, WAIT, DONE).
  - Function crc32_byte.
- One sub-module, crc32_word_update: purely combinational 32-bit crc_in + word -> crc_out, built from four chained byte steps. It is reused later by the writer/checker.

## Test plan
- Count 1 at base 0x0000, memory word 0x34333231 ("1234"), no waitrequest -> done at cycle 3 after start, crc_out=0x9BE3E0A3.
- Count 1 on word 0x00000000 -> crc_out=0x2144DF1C. Count 0 -> done 1 cycle after start, crc_out=0x00000000, no avm_read ever asserted.
- Base 0x1FFF, count 2 -> addresses issued are 0x1FFF then 0x0000; CRC equals the software model over those two words.
- Random 0–3 cycle waitrequest plus stray readdatavalid pulses while in REQ -> avm_address stays stable while stalled, exactly N reads are accepted, CRC is unchanged versus the zero-wait run.
- Reset asserted while in WAIT on word 5 of 10 -> avm_read=0 and busy=0 immediately. A late readdatavalid is ignored, and the next start reproduces the full-run CRC.
- With CRC_READER_CMP_EN: expected 0x9BE3E0A3 on "1234" -> crc_match=1. Expected 0x00000000 -> crc_match=0.
